// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm controller and its keypad/sensor front end.
// The i_/o_ prefixes name the direction as seen from the controller.
interface alarm_ctrl_if;
    logic       i_trip;
    logic [3:0] i_zone;
    logic       i_arm;
    logic       i_disarm;
    logic       o_siren;
    logic       o_armed;
    logic       o_pending;
    logic [2:0] o_state;
    logic [3:0] o_alarm_zone;

    modport slave (
        input  i_trip, i_zone, i_arm, i_disarm,
        output o_siren, o_armed, o_pending, o_state, o_alarm_zone
    );

    modport master (
        output i_trip, i_zone, i_arm, i_disarm,
        input  o_siren, o_armed, o_pending, o_state, o_alarm_zone
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Intruder alarm controller: synchronizes and debounces the sensor trip,
// then sequences exit delay, armed watch, entry grace and siren time.
module alarm_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int EXIT_CYCLES  = 8,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    alarm_ctrl_if.slave  bus
);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    localparam int TMAX_A = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int TMAX   = (TMAX_A > SIREN_CYCLES) ? TMAX_A : SIREN_CYCLES;
    localparam int TW     = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int DW     = $clog2(DEB_CYCLES + 1);

    logic          r_trip_s1;
    logic          r_trip_s2;
    logic [3:0]    r_zone_s1;
    logic [3:0]    r_zone_s2;
    logic [DW-1:0] r_deb;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_siren;
    logic [3:0]    r_alarm_zone;
    logic          w_trip_db;

    assign w_trip_db = (r_deb == DW'(DEB_CYCLES));

    // Two-flop synchronizers for the asynchronous sensor inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_trip_s1 <= 1'b0;
            r_trip_s2 <= 1'b0;
            r_zone_s1 <= 4'b0000;
            r_zone_s2 <= 4'b0000;
        end else begin
            r_trip_s1 <= bus.i_trip;
            r_trip_s2 <= r_trip_s1;
            r_zone_s1 <= bus.i_zone;
            r_zone_s2 <= r_zone_s1;
        end
    end

    // Debounce counter: counts consecutive high samples, saturating.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_deb <= '0;
        end else if (!r_trip_s2) begin
            r_deb <= '0;
        end else if (r_deb != DW'(DEB_CYCLES)) begin
            r_deb <= r_deb + DW'(1);
        end else begin
            r_deb <= r_deb;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_DISARMED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; disarm outranks arm and every timer expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_DISARMED: begin
                if (bus.i_arm && !bus.i_disarm) w_next_state = S_EXIT;
                else                            w_next_state = S_DISARMED;
            end
            S_EXIT: begin
                if (bus.i_disarm)                              w_next_state = S_DISARMED;
                else if (r_timer == TW'(EXIT_CYCLES - 1))      w_next_state = S_ARMED;
                else                                           w_next_state = S_EXIT;
            end
            S_ARMED: begin
                if (bus.i_disarm)   w_next_state = S_DISARMED;
                else if (w_trip_db) w_next_state = S_ENTRY;
                else                w_next_state = S_ARMED;
            end
            S_ENTRY: begin
                if (bus.i_disarm)                              w_next_state = S_DISARMED;
                else if (r_timer == TW'(ENTRY_CYCLES - 1))     w_next_state = S_ALARM;
                else                                           w_next_state = S_ENTRY;
            end
            S_ALARM: begin
                if (bus.i_disarm)                              w_next_state = S_DISARMED;
                else if (r_timer == TW'(SIREN_CYCLES - 1))     w_next_state = S_ARMED;
                else                                           w_next_state = S_ALARM;
            end
            default: w_next_state = S_DISARMED;
        endcase
    end

    // Shared phase timer, restarted on every state change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_next_state != r_state) begin
            r_timer <= '0;
        end else if (r_state == S_EXIT || r_state == S_ENTRY || r_state == S_ALARM) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= r_timer;
        end
    end

    // Siren is registered from the next state so it tracks ALARM with no lag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_siren <= 1'b0;
        end else begin
            r_siren <= (w_next_state == S_ALARM);
        end
    end

    // Zone record: accumulate while in ENTRY/ALARM, wipe only when re-arming.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alarm_zone <= 4'b0000;
        end else if (r_state == S_DISARMED && w_next_state == S_EXIT) begin
            r_alarm_zone <= 4'b0000;
        end else if (r_state == S_ENTRY || r_state == S_ALARM) begin
            r_alarm_zone <= r_alarm_zone | r_zone_s2;
        end else begin
            r_alarm_zone <= r_alarm_zone;
        end
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        bus.o_state      = r_state;
        bus.o_armed      = 1'b0;
        bus.o_pending    = 1'b0;
        bus.o_siren      = r_siren;
        bus.o_alarm_zone = r_alarm_zone;
        case (r_state)
            S_EXIT:  begin bus.o_armed = 1'b1; bus.o_pending = 1'b1; end
            S_ARMED: begin bus.o_armed = 1'b1; bus.o_pending = 1'b0; end
            S_ENTRY: begin bus.o_armed = 1'b1; bus.o_pending = 1'b1; end
            S_ALARM: begin bus.o_armed = 1'b1; bus.o_pending = 1'b0; end
            default: begin bus.o_armed = 1'b0; bus.o_pending = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: a cycle-level behavioural model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_alarm_ctrl;
    localparam int DEB = 4;
    localparam int EXT = 8;
    localparam int ENT = 16;
    localparam int SIR = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .DEB_CYCLES(DEB), .EXIT_CYCLES(EXT), .ENTRY_CYCLES(ENT), .SIREN_CYCLES(SIR)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: state as a number, time spent in it, run length of synced trip.
    int         m_st;
    int         m_since;
    int         m_run;
    logic [1:0] m_tsync;
    logic [3:0] m_z1, m_z2, m_zone;
    bit         m_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_since = 0; m_run = 0;
        m_tsync = 2'b00; m_z1 = 4'b0000; m_z2 = 4'b0000; m_zone = 4'b0000;
    endtask

    task automatic model_step();
        bit   tdb;
        int   ns;
        if (rst) begin
            model_reset();
        end else begin
            tdb = (m_run >= DEB);
            ns  = m_st;
            case (m_st)
                0: if (bus.i_arm && !bus.i_disarm) ns = 1;
                1: if (bus.i_disarm) ns = 0; else if (m_since + 1 == EXT) ns = 2;
                2: if (bus.i_disarm) ns = 0; else if (tdb) ns = 3;
                3: if (bus.i_disarm) ns = 0; else if (m_since + 1 == ENT) ns = 4;
                4: if (bus.i_disarm) ns = 0; else if (m_since + 1 == SIR) ns = 2;
                default: ns = 0;
            endcase
            if (m_st == 3 || m_st == 4) m_zone = m_zone | m_z2;
            if (ns == 1 && m_st != 1) m_zone = 4'b0000;
            m_since = (ns != m_st) ? 0 : m_since + 1;
            m_st    = ns;
            m_run   = m_tsync[1] ? m_run + 1 : 0;
            m_tsync = {m_tsync[0], bus.i_trip};
            m_z2    = m_z1;
            m_z1    = bus.i_zone;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_check) begin
            chk("model_state",   32'(bus.o_state), 32'(m_st));
            chk("model_armed",   32'(bus.o_armed), 32'(m_st != 0));
            chk("model_pending", 32'(bus.o_pending), 32'(m_st == 1 || m_st == 3));
            chk("model_siren",   32'(bus.o_siren), 32'(m_st == 4));
            chk("model_zone",    32'(bus.o_alarm_zone), 32'(m_zone));
        end
    end

    initial begin
        bus.i_trip = 1'b0; bus.i_zone = 4'b0000; bus.i_arm = 1'b0; bus.i_disarm = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        m_check = 1'b1;
        #2;
        chk("reset_state", 32'(bus.o_state), 32'd0);
        chk("reset_siren", 32'(bus.o_siren), 32'd0);
        chk("reset_zone",  32'(bus.o_alarm_zone), 32'd0);
        repeat (3) tick();

        // Release reset with arm already high: first edge must move to EXIT.
        bus.i_arm = 1'b1; rst = 1'b0;
        tick();
        chk("arm_first_edge", 32'(bus.o_state), 32'd1);
        bus.i_arm = 1'b0;
        repeat (7) tick();
        chk("exit_last_cycle", 32'(bus.o_state), 32'd1);
        tick();
        chk("armed_state",   32'(bus.o_state), 32'd2);
        chk("armed_flag",    32'(bus.o_armed), 32'd1);
        chk("armed_pending", 32'(bus.o_pending), 32'd0);

        // Three-cycle trip glitch (with a stray arm) must not qualify.
        bus.i_trip = 1'b1; bus.i_zone = 4'b0100; bus.i_arm = 1'b1;
        repeat (3) tick();
        bus.i_trip = 1'b0; bus.i_zone = 4'b0000; bus.i_arm = 1'b0;
        repeat (10) tick();
        chk("glitch_stays_armed", 32'(bus.o_state), 32'd2);

        // Held trip: ENTRY on the 7th edge, ALARM 16 edges later.
        bus.i_trip = 1'b1; bus.i_zone = 4'b0100;
        repeat (6) tick();
        chk("deb_not_yet", 32'(bus.o_state), 32'd2);
        tick();
        chk("entry_reached", 32'(bus.o_state), 32'd3);
        repeat (15) tick();
        chk("entry_last_cycle", 32'(bus.o_state), 32'd3);
        tick();
        chk("alarm_state", 32'(bus.o_state), 32'd4);
        chk("alarm_siren", 32'(bus.o_siren), 32'd1);
        chk("alarm_zone",  32'(bus.o_alarm_zone), 32'd4);

        // Siren times out and re-arms, keeping the zone record.
        bus.i_trip = 1'b0; bus.i_zone = 4'b0000;
        repeat (63) tick();
        chk("siren_last_cycle", 32'(bus.o_siren), 32'd1);
        tick();
        chk("rearm_state", 32'(bus.o_state), 32'd2);
        chk("rearm_siren", 32'(bus.o_siren), 32'd0);
        chk("rearm_zone",  32'(bus.o_alarm_zone), 32'd4);

        // A new trip on zone A re-alarms and accumulates zones.
        bus.i_trip = 1'b1; bus.i_zone = 4'b0001;
        repeat (7) tick();
        chk("retrip_entry", 32'(bus.o_state), 32'd3);
        repeat (16) tick();
        chk("retrip_alarm", 32'(bus.o_state), 32'd4);
        chk("retrip_zone",  32'(bus.o_alarm_zone), 32'd5);

        // arm and disarm together in ALARM: disarm wins, zone kept.
        bus.i_arm = 1'b1; bus.i_disarm = 1'b1;
        tick();
        bus.i_arm = 1'b0; bus.i_disarm = 1'b0; bus.i_trip = 1'b0; bus.i_zone = 4'b0000;
        chk("disarm_state", 32'(bus.o_state), 32'd0);
        chk("disarm_siren", 32'(bus.o_siren), 32'd0);
        chk("disarm_zone",  32'(bus.o_alarm_zone), 32'd5);
        tick();

        // Re-arming clears the record; disarm beats exit expiry.
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        chk("exit_clears_zone", 32'(bus.o_alarm_zone), 32'd0);
        repeat (7) tick();
        chk("exit_before_expiry", 32'(bus.o_state), 32'd1);
        bus.i_disarm = 1'b1;
        tick();
        bus.i_disarm = 1'b0;
        chk("disarm_beats_expiry", 32'(bus.o_state), 32'd0);

        // Full cycle to ALARM again, then asynchronous reset mid-ALARM.
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        repeat (8) tick();
        bus.i_trip = 1'b1; bus.i_zone = 4'b0010;
        repeat (7 + 16 + 10) tick();
        chk("pre_reset_alarm", 32'(bus.o_state), 32'd4);
        chk("pre_reset_zone",  32'(bus.o_alarm_zone), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_state",   32'(bus.o_state), 32'd0);
        chk("async_siren",   32'(bus.o_siren), 32'd0);
        chk("async_zone",    32'(bus.o_alarm_zone), 32'd0);
        chk("async_armed",   32'(bus.o_armed), 32'd0);
        chk("async_pending", 32'(bus.o_pending), 32'd0);
        tick();
        bus.i_trip = 1'b0; bus.i_zone = 4'b0000;
        rst = 1'b0;
        repeat (4) tick();
        chk("post_reset_idle", 32'(bus.o_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized-high cycles required to qualify a trip.
REQ-002 Parameter EXIT_CYCLES, default 8: exit delay after arming, sensors ignored.
REQ-003 Parameter ENTRY_CYCLES, default 16: grace period between qualified trip and siren.
REQ-004 Parameter SIREN_CYCLES, default 64: siren on-time before automatic re-arm.
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 trip  in  1  combined sensor alarm from the upstream sensor stage; asynchronous to clk.
REQ-008 zone  in  4  raw sensor lines (A..D = bits 0..3); asynchronous to clk.
REQ-009 arm  in  1  synchronous arm request, sampled every cycle.
REQ-010 disarm  in  1  synchronous disarm request, sampled every cycle.
REQ-011 siren  out  1  siren drive.
REQ-012 armed  out  1  high in EXIT, ARMED, ENTRY and ALARM.
REQ-013 pending  out  1  high in EXIT or ENTRY (indicator LED).
REQ-014 state  out  3  DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4.
REQ-015 alarm_zone  out  4  latched record of the zones that caused the alarm.

Function
REQ-016 trip and zone SHALL each pass through a two-flop synchronizer before any use.
REQ-017 The debounce counter SHALL increment, saturating at DEB_CYCLES, while synchronized trip is 1, and clear to 0 on any cycle it is 0.
REQ-018 trip_db SHALL be 1 exactly when the counter equals DEB_CYCLES; trip held high from edge N gives trip_db high after edge N+DEB_CYCLES+1.
REQ-019 A single timer SHALL load 0 on every state entry and increment once per cycle in EXIT, ENTRY and ALARM.
REQ-020 DISARMED: arm=1 and disarm=0 -> EXIT; otherwise remain.
REQ-021 EXIT: disarm -> DISARMED; timer reaching EXIT_CYCLES-1 -> ARMED; trip_db ignored.
REQ-022 ARMED: disarm -> DISARMED; else trip_db=1 -> ENTRY.
REQ-023 ENTRY: disarm -> DISARMED; timer reaching ENTRY_CYCLES-1 -> ALARM.
REQ-024 ALARM: disarm -> DISARMED; timer reaching SIREN_CYCLES-1 -> ARMED, with alarm_zone retained.
REQ-025 disarm SHALL take priority over arm and over any timer expiry in the same cycle.
REQ-026 arm SHALL be ignored in every state except DISARMED.
REQ-027 A trip_db still high on re-entry to ARMED SHALL start a new ENTRY the next cycle.
REQ-028 In ENTRY and ALARM, alarm_zone SHALL OR in the synchronized zone bits every cycle.
REQ-029 alarm_zone SHALL clear to 0 on any transition to EXIT.
REQ-030 alarm_zone SHALL be preserved on transition to DISARMED so the user can read it.
REQ-031 siren SHALL be registered and equal 1 exactly for the cycles in which state=ALARM.
REQ-032 armed, pending and state SHALL be derived from the state register with no added latency.

Reset
REQ-033 While rst=1, the block SHALL hold state=DISARMED, siren=0, armed=0, pending=0 and alarm_zone=0, and clear the synchronizers, debounce counter and timer.
REQ-034 Asserting rst in any state, including mid-ALARM, SHALL force these values immediately, without waiting for a clock edge.
REQ-035 After rst is released, the first transition SHALL be taken on the first rising edge of clk.

Verification
REQ-036 Pulse arm for 1 cycle -> state=1 for 8 cycles, then state=2 with armed=1 and pending=0.
REQ-037 In ARMED, hold trip=1 and zone=4'b0100 -> ENTRY after the debounce latency, ALARM 16 cycles later, siren=1, alarm_zone=4'b0100.
REQ-038 In ARMED, pulse trip for 3 cycles -> trip_db never asserts and state stays 2.
REQ-039 In ALARM, assert arm and disarm in the same cycle -> next state=0, siren=0, alarm_zone retained.
REQ-040 Let ALARM run with trip low -> siren drops after 64 cycles and state=2; a new trip re-alarms.
REQ-041 Assert rst asynchronously mid-ALARM -> siren=0 and state=0 before the next clk edge, and alarm_zone=0.
